// File: rtl/modmul_arb_pkg.sv
// modmul_arb_pkg: shared types and round-robin pick helper for the modmul request arbiter
package modmul_arb_pkg;
  localparam int MAX_REQ = 16;
  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;
  typedef struct packed {
    logic    hit;
    req_id_t id;
  } pick_t;
  function automatic int id_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] val, input req_id_t ptr, input int n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % n;
      if (i < n && val[req_id_t'(k)]) begin
        p.hit = 1'b1;
        p.id  = req_id_t'(k);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/modmul_req_arbiter_if.sv
// modmul_req_arbiter_if: requester, multiplier-issue and response channels of the arbiter
interface modmul_req_arbiter_if #(
  parameter int DAT_BITS = 256,
  parameter int NUM_REQ  = 4
);
  logic [NUM_REQ-1:0]               i_req_val, o_req_rdy, o_rsp_val, i_rsp_rdy;
  logic [NUM_REQ-1:0][DAT_BITS-1:0] i_req_a, i_req_b;
  logic                             o_mul_val, i_mul_rdy, i_mul_val, o_mul_rdy;
  logic [DAT_BITS-1:0]              o_mul_a, o_mul_b, i_mul_dat, o_rsp_dat;
  modport master (
    input  i_req_val, i_req_a, i_req_b, i_mul_rdy, i_mul_val, i_mul_dat, i_rsp_rdy,
    output o_req_rdy, o_mul_val, o_mul_a, o_mul_b, o_mul_rdy, o_rsp_val, o_rsp_dat
  );
  modport slave (
    output i_req_val, i_req_a, i_req_b, i_mul_rdy, i_mul_val, i_mul_dat, i_rsp_rdy,
    input  o_req_rdy, o_mul_val, o_mul_a, o_mul_b, o_mul_rdy, o_rsp_val, o_rsp_dat
  );
endinterface

// File: rtl/tag_fifo.sv
// tag_fifo: synchronous FIFO of requester tags for in-flight multiplier operations
module tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;
  assign count = wp - rp;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/modmul_req_arbiter.sv
// modmul_req_arbiter: round-robin arbiter and in-order response router for a shared modular multiplier
module modmul_req_arbiter
  import modmul_arb_pkg::*;
#(
  parameter  int DAT_BITS = 256,
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_OUT  = 16,
  localparam int ID_BITS  = id_bits(NUM_REQ),
  localparam int CW       = $clog2(MAX_OUT) + 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  modmul_req_arbiter_if.master  bus,
  output logic [CW-1:0]         o_outstanding,
  output logic                  o_err
);
  pick_t              pick;
  logic               unused_pick;
  logic [ID_BITS-1:0] rr_ptr, win, head;
  logic               push, pop, full, empty;
  assign pick        = rr_pick(MAX_REQ'(bus.i_req_val), req_id_t'(rr_ptr), NUM_REQ);
  assign unused_pick = ^pick;
  assign win         = ID_BITS'(pick.id);
  assign push        = !areset && pick.hit && (!bus.o_mul_val || bus.i_mul_rdy) && !full;
  assign pop         = bus.i_mul_val && bus.o_mul_rdy && !empty;
  assign bus.o_req_rdy = push ? NUM_REQ'(1) << win : '0;
  assign bus.o_rsp_val = (!areset && bus.i_mul_val && !empty) ? NUM_REQ'(1) << head : '0;
  assign bus.o_rsp_dat = bus.i_mul_dat;
  assign bus.o_mul_rdy = !areset && (empty ? bus.i_mul_val : bus.i_rsp_rdy[head]);
  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.o_mul_val <= 1'b0;
      bus.o_mul_a   <= '0;
      bus.o_mul_b   <= '0;
      rr_ptr        <= '0;
      o_err         <= 1'b0;
    end else begin
      if (push) begin
        bus.o_mul_val <= 1'b1;
        bus.o_mul_a   <= bus.i_req_a[win];
        bus.o_mul_b   <= bus.i_req_b[win];
        rr_ptr        <= win == ID_BITS'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end else if (bus.i_mul_rdy) bus.o_mul_val <= 1'b0;
      if (bus.i_mul_val && empty) o_err <= 1'b1;
    end
  end
  tag_fifo #(.DEPTH(MAX_OUT), .WIDTH(ID_BITS)) u_tags (
    .clk  (aclk),
    .rst  (areset),
    .push (push),
    .din  (win),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(o_outstanding)
  );
endmodule

// File: tb/tb_modmul_req_arbiter.sv
// tb_modmul_req_arbiter: randomized and directed self-checking bench for modmul_req_arbiter
module tb_modmul_req_arbiter;
  localparam int DAT = 256, N = 4, MO = 16, LAT = 5;
  localparam logic [DAT-1:0] P = 256'd100000000;
  typedef struct {
    logic [DAT-1:0] d;
    int             due;
  } res_t;
  logic aclk = 1'b0, areset = 1'b1;
  logic [4:0] outstanding;
  logic err;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [N-1:0] pend = '0, rsp_rdy = '1;
  logic mrdy = 1'b1, hold = 1'b0, spur = 1'b0, autoreq = 1'b0;
  logic [DAT-1:0] ra [N], rb [N];
  res_t mq[$];
  int grants[$], owners[$];
  int mtag[$];
  int mrr = 0;
  logic mmv = 1'b0, merr = 1'b0;
  logic [DAT-1:0] mma = '0, mmb = '0;
  logic [N-1:0] e_rdy, e_rsp;
  logic e_mrdy, e_empty;
  int e_w, e_idx, e_h;
  modmul_req_arbiter_if #(.DAT_BITS(DAT), .NUM_REQ(N)) bus ();
  modmul_req_arbiter #(.DAT_BITS(DAT), .NUM_REQ(N), .MAX_OUT(MO)) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .o_outstanding(outstanding), .o_err(err)
  );
  always #10 aclk = ~aclk;
  task automatic chk(input string name, input logic [DAT-1:0] act, input logic [DAT-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic expire(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait expired before condition reached at %0t", name, $time);
  endtask
  function automatic logic [DAT-1:0] mulmod(input logic [DAT-1:0] a, input logic [DAT-1:0] b);
    logic [2*DAT-1:0] p;
    p = {{DAT{1'b0}}, a} * {{DAT{1'b0}}, b};
    return DAT'(p % {{DAT{1'b0}}, P});
  endfunction
  task automatic apply();
    bus.i_req_val = pend;
    for (int k = 0; k < N; k++) begin
      bus.i_req_a[k] = ra[k];
      bus.i_req_b[k] = rb[k];
    end
    bus.i_mul_rdy = mrdy;
    bus.i_rsp_rdy = rsp_rdy;
    bus.i_mul_val = spur || (!hold && mq.size() > 0 && mq[0].due <= cyc);
    bus.i_mul_dat = mq.size() > 0 ? mq[0].d : DAT'($urandom);
  endtask
  task automatic settle();
    apply();
    #1;
  endtask
  task automatic req(input int k, input logic [DAT-1:0] a, input logic [DAT-1:0] b);
    pend[k] = 1'b1;
    ra[k] = a;
    rb[k] = b;
  endtask
  task automatic tick();
    logic [N-1:0] acc, rv;
    logic iss, tk;
    logic [DAT-1:0] ia, ib;
    @(negedge aclk);
    acc = bus.o_req_rdy;
    rv = bus.o_rsp_val;
    iss = bus.o_mul_val && bus.i_mul_rdy;
    tk = bus.i_mul_val && bus.o_mul_rdy;
    ia = bus.o_mul_a;
    ib = bus.o_mul_b;
    @(posedge aclk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        grants.push_back(k);
        pend[k] = autoreq;
        ra[k] = DAT'($urandom);
        rb[k] = DAT'($urandom);
      end
      if (rv[k] && tk) owners.push_back(k);
    end
    if (tk && mq.size() > 0) void'(mq.pop_front());
    if (iss) mq.push_back('{d: mulmod(ia, ib), due: cyc + LAT - 1});
    apply();
    #2;
  endtask
  task automatic do_reset();
    areset = 1'b1;
    settle();
    tick();
    areset = 1'b0;
    pend = '0;
    mq.delete();
    grants.delete();
    owners.delete();
    settle();
  endtask
  task automatic drain();
    int i;
    autoreq = 1'b0;
    hold = 1'b0;
    mrdy = 1'b1;
    rsp_rdy = '1;
    spur = 1'b0;
    settle();
    for (i = 0; i < 300 && !(pend == 0 && outstanding == 0 && mq.size() == 0 && !bus.o_mul_val); i++) tick();
    if (i == 300) expire("drain");
  endtask
  initial begin
    @(posedge aclk);
    forever begin
      @(negedge aclk);
      e_w = -1;
      for (int i = N - 1; i >= 0; i--) begin
        e_idx = (mrr + i) % N;
        if (bus.i_req_val[e_idx[1:0]]) e_w = e_idx;
      end
      e_empty = mtag.size() == 0;
      e_h = e_empty ? 0 : mtag[0];
      e_rdy = (!areset && (!mmv || bus.i_mul_rdy) && mtag.size() < MO && e_w >= 0) ? N'(1) << e_w : '0;
      e_rsp = (!areset && bus.i_mul_val && !e_empty) ? N'(1) << e_h : '0;
      e_mrdy = !areset && (e_empty ? bus.i_mul_val : bus.i_rsp_rdy[e_h[1:0]]);
      chk("req_rdy", bus.o_req_rdy, e_rdy);
      chk("mul_val", bus.o_mul_val, mmv);
      if (mmv) begin
        chk("mul_a", bus.o_mul_a, mma);
        chk("mul_b", bus.o_mul_b, mmb);
      end
      chk("rsp_val", bus.o_rsp_val, e_rsp);
      chk("rsp_dat", bus.o_rsp_dat, bus.i_mul_dat);
      chk("mul_rdy", bus.o_mul_rdy, e_mrdy);
      chk("outstanding", outstanding, DAT'(mtag.size()));
      chk("err", err, merr);
      if (areset) begin
        mtag.delete();
        mrr = 0;
        mmv = 1'b0;
        merr = 1'b0;
        mma = '0;
        mmb = '0;
      end else begin
        if (bus.i_mul_val && e_empty) merr = 1'b1;
        if (bus.i_mul_val && e_mrdy && !e_empty) void'(mtag.pop_front());
        if (e_rdy != 0) begin
          mtag.push_back(e_w);
          mmv = 1'b1;
          mma = bus.i_req_a[e_w[1:0]];
          mmb = bus.i_req_b[e_w[1:0]];
          mrr = (e_w + 1) % N;
        end else if (bus.i_mul_rdy) mmv = 1'b0;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int i;
    for (int k = 0; k < N; k++) begin
      ra[k] = '0;
      rb[k] = '0;
    end
    do_reset();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_mul_val", bus.o_mul_val, 0);
    chk("rst_mul_a", bus.o_mul_a, 0);
    chk("rst_req_rdy", bus.o_req_rdy, 0);
    chk("rst_mul_rdy", bus.o_mul_rdy, 0);
    req(2, 7, 9);
    settle();
    chk("single_grant", bus.o_req_rdy, 4'b0100);
    tick();
    chk("single_out1", outstanding, 1);
    chk("single_issue_a", bus.o_mul_a, 7);
    for (i = 0; i < 20 && bus.o_rsp_val == 0; i++) tick();
    if (i == 20) expire("single_rsp");
    chk("single_rsp_val", bus.o_rsp_val, 4'b0100);
    chk("single_rsp_dat", bus.o_rsp_dat, 63);
    chk("single_out_before_pop", outstanding, 1);
    tick();
    chk("single_out0", outstanding, 0);
    do_reset();
    autoreq = 1'b1;
    for (int k = 0; k < N; k++) req(k, k + 1, k + 10);
    settle();
    for (i = 0; i < 40 && grants.size() < 8; i++) tick();
    autoreq = 1'b0;
    for (int j = 0; j < 8; j++) chk("fair_grant", j < grants.size() ? grants[j] : -1, j % 4);
    drain();
    for (int j = 0; j < 8; j++) chk("fair_owner", j < owners.size() ? owners[j] : -1, j % 4);
    do_reset();
    hold = 1'b1;
    autoreq = 1'b1;
    for (int k = 0; k < N; k++) req(k, 3 * k + 2, 5 * k + 1);
    settle();
    for (i = 0; i < 60 && outstanding < 16; i++) tick();
    chk("full_grants", grants.size(), 16);
    chk("full_out16", outstanding, 16);
    chk("full_rdy", bus.o_req_rdy, 0);
    hold = 1'b0;
    settle();
    chk("full_pop_rdy", bus.o_req_rdy, 0);
    chk("full_pop_mrdy", bus.o_mul_rdy, 1);
    hold = 1'b1;
    tick();
    chk("full_out15", outstanding, 15);
    chk("full_resume", bus.o_req_rdy != 0, 1);
    drain();
    mrdy = 1'b0;
    req(1, 'h1234, 'h5678);
    settle();
    tick();
    req(3, 11, 12);
    settle();
    for (int j = 0; j < 10; j++) begin
      chk("bp_a", bus.o_mul_a, 'h1234);
      chk("bp_b", bus.o_mul_b, 'h5678);
      chk("bp_hold_rdy", bus.o_req_rdy, 0);
      tick();
    end
    drain();
    rsp_rdy = 4'b1101;
    req(1, 3, 4);
    settle();
    for (i = 0; i < 30 && !bus.i_mul_val; i++) tick();
    if (i == 30) expire("rbp_result");
    for (int j = 0; j < 3; j++) begin
      chk("rbp_mrdy", bus.o_mul_rdy, 0);
      chk("rbp_rsp_val", bus.o_rsp_val, 4'b0010);
      tick();
    end
    rsp_rdy = '1;
    settle();
    chk("rbp_release", bus.o_mul_rdy, 1);
    chk("rbp_dat", bus.o_rsp_dat, 12);
    drain();
    spur = 1'b1;
    settle();
    chk("spur_mrdy", bus.o_mul_rdy, 1);
    chk("spur_rsp", bus.o_rsp_val, 0);
    chk("spur_err_before", err, 0);
    spur = 1'b0;
    tick();
    chk("spur_err", err, 1);
    tick();
    tick();
    tick();
    chk("spur_err_sticky", err, 1);
    hold = 1'b1;
    autoreq = 1'b1;
    for (int k = 0; k < N; k++) req(k, k + 20, k + 30);
    settle();
    for (i = 0; i < 20 && outstanding < 5; i++) tick();
    autoreq = 1'b0;
    chk("mid_out5", outstanding, 5);
    do_reset();
    hold = 1'b0;
    settle();
    chk("mid_out0", outstanding, 0);
    chk("mid_mul_val", bus.o_mul_val, 0);
    chk("mid_mul_a", bus.o_mul_a, 0);
    chk("mid_mul_b", bus.o_mul_b, 0);
    chk("mid_err", err, 0);
    chk("mid_rsp_val", bus.o_rsp_val, 0);
    for (int k = 0; k < N; k++) req(k, k + 40, k + 50);
    settle();
    chk("mid_next_grant", bus.o_req_rdy, 4'b0001);
    drain();
    for (int c = 0; c < 3000; c++) begin
      mrdy = $urandom_range(3) != 0;
      for (int k = 0; k < N; k++) begin
        rsp_rdy[k] = $urandom_range(3) != 0;
        if (!pend[k] && $urandom_range(2) == 0) req(k, DAT'($urandom), DAT'($urandom));
      end
      settle();
      tick();
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
